// File: rtl/sub_seq_ctrl.sv
// Nibble-serial wide subtractor controller.
// Drives one external 4-bit subtractor slice, LS nibble first.
module sub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic [3:0]           slice_a,
  output logic [3:0]           slice_b,
  output logic                 slice_bin,
  input  logic [3:0]           slice_diff,
  input  logic                 slice_bout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nxt;
  logic          borrow;
  logic          run;

  assign run  = (state == RUN);
  assign busy = run;

  assign slice_a   = run ? a_reg[{cnt, 2'b00} +: 4] : 4'h0;
  assign slice_b   = run ? b_reg[{cnt, 2'b00} +: 4] : 4'h0;
  assign slice_bin = run ? borrow : 1'b0;

  // Work register with this cycle's slice nibble merged in.
  always_comb begin
    work_nxt = work;
    work_nxt[{cnt, 2'b00} +: 4] = slice_diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      work   <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            cnt    <= '0;
            work   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          work   <= work_nxt;
          borrow <= slice_bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= work_nxt;
            bout  <= slice_bout;
            zero  <= (work_nxt == '0);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
